inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Small synchronous FIFO between the fetch-stage aligner and the decoder.
- Each entry holds one aligned 32-bit instruction and its PC.
- Absorbs decoder stalls without losing aligned instructions, and drives the aligner's stop input so held instructions are not re-counted.
- Flush discards all buffered instructions in one cycle, for redirect or branch mispredict.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rstn  input  1  reset; asynchronous, active-low.
- i_flush  input  1  discard all entries this cycle.
- i_inst_vld  input  1  aligned instruction valid from the aligner.
- i_inst_pc  input  `xlen  PC of the aligned instruction.
- i_inst  input  `ilen  aligned instruction.
- o_stop  output  1  to the aligner's stop input; asserted when the queue is full.
- o_inst_vld  output  1  head entry valid toward the decoder.
- o_inst_pc  output  `xlen  head PC.
- o_inst  output  `ilen  head instruction.
- i_dec_rdy  input  1  decoder accepts the head this cycle.
- o_count  output  AW+1  number of occupied entries.

Behaviour:
- State:
  - storage array mem[DEPTH] of {pc, inst}, not reset;
  - wptr and rptr, AW bits each;
  - cnt, AW+1 bits.
- Reset (asynchronous, i_rstn=0):
  - wptr=0, rptr=0, cnt=0;
  - therefore o_inst_vld=0, o_stop=0, o_count=0;
  - o_inst and o_inst_pc drive 0 while empty.
- Full and empty flags are decoded from the registered cnt only:
  - full = (cnt==DEPTH);
  - empty = (cnt==0).
- o_stop = full. It is purely registered-state derived, so there is no combinational path from i_dec_rdy to o_stop.
- push = i_inst_vld & ~full & ~i_flush.
  - On push: mem[wptr] <= {i_inst_pc, i_inst}; wptr <= wptr+1, wrapping modulo DEPTH.
- pop = ~empty & i_dec_rdy & ~i_flush.
  - On pop: rptr <= rptr+1, wrapping modulo DEPTH.
- cnt update:
  - cnt+1 on push only;
  - cnt-1 on pop only;
  - unchanged on push and pop together.
- Outputs:
  - o_inst_vld = ~empty;
  - {o_inst_pc, o_inst} = empty ? 0 : mem[rptr], combinational read of the head.
- Latency: an instruction pushed in cycle N appears on o_inst_vld in cycle N+1. There is no bypass path.
- Full with i_dec_rdy=1:
  - pop occurs and push is blocked, because o_stop was high;
  - the next cycle cnt=DEPTH-1 and o_stop drops.
  - The aligner holds its output while stopped, so the blocked instruction is presented again and nothing is lost.
- Empty with i_dec_rdy=1: no pop; pointers unchanged.
- Flush:
  - wptr, rptr and cnt are all set to 0 on the next edge, regardless of push or pop;
  - any concurrent push is dropped;
  - a concurrent decoder "accept" is not counted, because the decoder is flushed too;
  - o_inst_vld=0 in the cycle after the flush.
- Flush while empty: no effect. Flush and reset together: reset dominates.
- Pointer wrap: after DEPTH pushes, wptr returns to 0. FIFO order is preserved across the wrap.

Decomposition:
- `xlen_def and `ilen_def (and the `xlen/`ilen widths) come from the shared config.v.
- Add `ifq_depth to config.v as the default for DEPTH.
- No sub-module is needed. If a generic sync_fifo is later added to the codebase, this block becomes a thin instance of it plus the flush and zero-masking logic.

Test Plan:
- Reset then idle: i_rstn low 3 cycles, then high with i_inst_vld=0 -> o_inst_vld=0, o_stop=0, o_count=0, o_inst=0.
- Pass-through:
  - stimulus: push pc=0x80000000 inst=0x00000013 with i_dec_rdy=1;
  - next cycle: o_inst_vld=1, o_inst_pc=0x80000000, o_inst=0x00000013;
  - cycle after: o_count=0.
- Fill and stall:
  - stimulus: i_dec_rdy=0, push pc 0x100, 0x104, 0x108, 0x10C;
  - -> o_count=4 and o_stop=1; a fifth pc 0x110 held on input is not written;
  - then i_dec_rdy=1 -> outputs 0x100, 0x104, 0x108, 0x10C, 0x110 in order.
- Simultaneous push and pop at cnt=2 -> o_count stays 2 and order is preserved.
- Wrap-around: 10 push/pop pairs with pcs 0x200+4k -> the PC sequence is strictly in order, with wptr wrapping twice.
- Flush:
  - stimulus: with 3 entries, assert i_flush together with i_inst_vld=1 pc=0x300;
  - -> next cycle o_count=0, o_inst_vld=0, and 0x300 is never output;
  - a following push of pc=0x400 -> 0x400 is the next head.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared widths and entry layout for the fetch-to-decode instruction queue.
// XLEN/ILEN/IFQ_DEPTH stand in for the codebase-wide xlen/ilen/ifq_depth defaults.
package inst_fetch_queue_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ILEN      = 32;
  localparam int unsigned IFQ_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } ifq_entry_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// Instruction queue between the fetch aligner and the decoder.
// Stop back-pressures the aligner when full; flush empties the queue in one cycle.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_flush,
  input  logic            i_inst_vld,
  input  logic [XLEN-1:0] i_inst_pc,
  input  logic [ILEN-1:0] i_inst,
  output logic            o_stop,
  output logic            o_inst_vld,
  output logic [XLEN-1:0] o_inst_pc,
  output logic [ILEN-1:0] o_inst,
  input  logic            i_dec_rdy,
  output logic [AW:0]     o_count
);

  localparam logic [AW:0] CntFull = (AW+1)'(DEPTH);

  ifq_entry_t mem [DEPTH];
  ifq_entry_t head;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full, empty, push, pop;

  // Flags come from registered count only, so o_stop has no path from i_dec_rdy.
  assign full  = (cnt_q == CntFull);
  assign empty = (cnt_q == '0);
  assign push  = i_inst_vld & ~full & ~i_flush;
  assign pop   = ~empty & i_dec_rdy & ~i_flush;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (i_flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is deliberately not reset; empty masking hides stale contents.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wptr_q] <= '{pc: i_inst_pc, inst: i_inst};
    end
  end

  always_comb begin
    head = '0;
    if (!empty) head = mem[rptr_q];
  end

  assign o_stop     = full;
  assign o_inst_vld = ~empty;
  assign o_inst_pc  = head.pc;
  assign o_inst     = head.inst;
  assign o_count    = cnt_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic            clk;
  logic            rstn;
  logic            flush;
  logic            inst_vld;
  logic [XLEN-1:0] inst_pc;
  logic [ILEN-1:0] inst;
  logic            stop;
  logic            out_vld;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_inst;
  logic            dec_rdy;
  logic [AW:0]     count;

  int vectors = 0;
  int errors  = 0;

  ifq_entry_t model_q[$];

  inst_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_flush    (flush),
    .i_inst_vld (inst_vld),
    .i_inst_pc  (inst_pc),
    .i_inst     (inst),
    .o_stop     (stop),
    .o_inst_vld (out_vld),
    .o_inst_pc  (out_pc),
    .o_inst     (out_inst),
    .i_dec_rdy  (dec_rdy),
    .o_count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock: the model applies the FIFO rules to the inputs present at the edge.
  task automatic tick();
    bit m_push, m_pop;
    ifq_entry_t e;
    m_push = inst_vld && (model_q.size() < DEPTH) && !flush;
    m_pop  = (model_q.size() != 0) && dec_rdy && !flush;
    e.pc   = inst_pc;
    e.inst = inst;
    @(posedge clk);
    if (!rstn || flush) begin
      model_q.delete();
    end else begin
      if (m_pop) void'(model_q.pop_front());
      if (m_push) model_q.push_back(e);
    end
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; inst_vld = 1'b0; inst_pc = '0; inst = '0; dec_rdy = 1'b0;
  endtask

  task automatic drain();
    inst_vld = 1'b0; dec_rdy = 1'b1; flush = 1'b0;
    for (int i = 0; i < 2 * DEPTH && model_q.size() != 0; i++) tick();
    dec_rdy = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (3) tick();
    vectors++;
    if (out_vld !== 1'b0 || stop !== 1'b0 || count !== '0) begin
      $display("FAIL reset_held: vld=%b stop=%b count=%0d, required 0/0/0", out_vld, stop, count);
      errors++;
    end
    rstn = 1'b1;
    tick();
    vectors++;
    if (out_vld !== 1'b0 || stop !== 1'b0 || count !== '0 || out_inst !== '0 || out_pc !== '0) begin
      $display("FAIL reset_idle: vld=%b stop=%b count=%0d inst=%h pc=%h, required all 0",
               out_vld, stop, count, out_inst, out_pc);
      errors++;
    end
  endtask

  task automatic test_pass_through();
    inst_vld = 1'b1; inst_pc = 32'h8000_0000; inst = 32'h0000_0013; dec_rdy = 1'b1;
    tick();
    inst_vld = 1'b0;
    vectors++;
    if (out_vld !== 1'b1 || out_pc !== 32'h8000_0000 || out_inst !== 32'h0000_0013) begin
      $display("FAIL pass_head: vld=%b pc=%h inst=%h, required 1/80000000/00000013",
               out_vld, out_pc, out_inst);
      errors++;
    end
    tick();
    vectors++;
    if (count !== '0 || out_vld !== 1'b0) begin
      $display("FAIL pass_drained: count=%0d vld=%b, required 0/0", count, out_vld);
      errors++;
    end
  endtask

  task automatic test_fill_stall();
    logic [XLEN-1:0] got[$];
    bit accept;
    dec_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      inst_vld = 1'b1; inst_pc = 32'h100 + 32'(4 * k); inst = $urandom;
      tick();
    end
    inst_pc = 32'h110; inst = $urandom;
    tick();
    vectors++;
    if (count !== 3'd4 || stop !== 1'b1) begin
      $display("FAIL fill_full: count=%0d stop=%b, required 4/1", count, stop);
      errors++;
    end
    dec_rdy = 1'b1;
    for (int c = 0; c < 20 && got.size() < 5; c++) begin
      if (out_vld) got.push_back(out_pc);
      accept = inst_vld && !stop;
      tick();
      if (accept) inst_vld = 1'b0;
    end
    vectors++;
    if (got.size() != 5) begin
      $display("FAIL fill_drain_count: got %0d outputs, required 5", got.size());
      errors++;
    end
    for (int k = 0; k < got.size(); k++) begin
      vectors++;
      if (got[k] !== 32'h100 + 32'(4 * k)) begin
        $display("FAIL fill_order[%0d]: pc=%h, required %h", k, got[k], 32'h100 + 32'(4 * k));
        errors++;
      end
    end
    drain();
  endtask

  task automatic test_simultaneous();
    dec_rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      inst_vld = 1'b1; inst_pc = 32'h500 + 32'(4 * k); inst = $urandom;
      tick();
    end
    dec_rdy = 1'b1;
    for (int k = 2; k < 4; k++) begin
      inst_pc = 32'h500 + 32'(4 * k); inst = $urandom;
      tick();
      vectors++;
      if (count !== 3'd2 || out_pc !== 32'h500 + 32'(4 * (k - 1))) begin
        $display("FAIL simul[%0d]: count=%0d head=%h, required 2/%h",
                 k, count, out_pc, 32'h500 + 32'(4 * (k - 1)));
        errors++;
      end
    end
    inst_vld = 1'b0;
    tick();
    vectors++;
    if (out_pc !== 32'h50C || count !== 3'd1) begin
      $display("FAIL simul_tail: head=%h count=%0d, required 50c/1", out_pc, count);
      errors++;
    end
    drain();
  endtask

  task automatic test_wrap();
    int idx = 0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    dec_rdy = 1'b1;
    for (int k = 0; k < 11; k++) begin
      inst_vld = (k < 10);
      inst_pc = 32'h200 + 32'(4 * k); inst = $urandom;
      if (out_vld) begin
        vectors++;
        if (out_pc !== 32'h200 + 32'(4 * idx)) begin
          $display("FAIL wrap_order[%0d]: pc=%h, required %h", idx, out_pc, 32'h200 + 32'(4 * idx));
          errors++;
        end
        idx++;
      end
      tick();
    end
    vectors++;
    if (idx != 10 || count !== '0) begin
      $display("FAIL wrap_total: popped=%0d count=%0d, required 10/0", idx, count);
      errors++;
    end
    inst_vld = 1'b0;
  endtask

  task automatic test_flush();
    dec_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      inst_vld = 1'b1; inst_pc = 32'h380 + 32'(4 * k); inst = $urandom;
      tick();
    end
    flush = 1'b1; inst_vld = 1'b1; inst_pc = 32'h300; dec_rdy = 1'b1;
    tick();
    flush = 1'b0; inst_vld = 1'b0;
    vectors++;
    if (count !== '0 || out_vld !== 1'b0 || out_pc !== '0) begin
      $display("FAIL flush_empty: count=%0d vld=%b pc=%h, required 0/0/0", count, out_vld, out_pc);
      errors++;
    end
    dec_rdy = 1'b0; inst_vld = 1'b1; inst_pc = 32'h400; inst = 32'h0000_0033;
    tick();
    inst_vld = 1'b0;
    vectors++;
    if (out_vld !== 1'b1 || out_pc !== 32'h400 || out_inst !== 32'h33 || count !== 3'd1) begin
      $display("FAIL flush_next: vld=%b pc=%h inst=%h count=%0d, required 1/400/33/1",
               out_vld, out_pc, out_inst, count);
      errors++;
    end
    drain();
  endtask

  task automatic test_random();
    logic [XLEN-1:0] exp_pc;
    logic [ILEN-1:0] exp_inst;
    for (int c = 0; c < 600; c++) begin
      inst_vld = ($urandom_range(0, 3) != 0);
      dec_rdy  = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 29) == 0);
      inst_pc  = $urandom;
      inst     = $urandom;
      tick();
      exp_pc   = (model_q.size() != 0) ? model_q[0].pc : '0;
      exp_inst = (model_q.size() != 0) ? model_q[0].inst : '0;
      vectors++;
      if (count !== 3'(model_q.size()) || out_vld !== (model_q.size() != 0) ||
          stop !== (model_q.size() == DEPTH) || out_pc !== exp_pc || out_inst !== exp_inst) begin
        $display("FAIL random[%0d]: count=%0d vld=%b stop=%b pc=%h inst=%h, required %0d/%b/%b/%h/%h",
                 c, count, out_vld, stop, out_pc, out_inst, model_q.size(),
                 model_q.size() != 0, model_q.size() == DEPTH, exp_pc, exp_inst);
        errors++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    test_reset();
    test_pass_through();
    test_fill_stall();
    test_simultaneous();
    test_wrap();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
